// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: datapath width, opcode field values,
// ALU control encodings and the decoded instruction class.
package legv8_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  // R-type / D-type opcodes, instruction[31:21]
  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LSL  = 11'h69B;
  localparam logic [10:0] OPC_LSR  = 11'h69A;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_HALT = 11'h7FF;

  // I-type opcodes, instruction[31:22]
  localparam logic [9:0] OPC_ADDI = 10'h244;
  localparam logic [9:0] OPC_SUBI = 10'h344;

  // CB-type opcodes, instruction[31:24]
  localparam logic [7:0] OPC_CBZ  = 8'hB4;
  localparam logic [7:0] OPC_CBNZ = 8'hB5;

  // B-type opcode, instruction[31:26]
  localparam logic [5:0] OPC_B = 6'h05;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_LSL  = 4'b0011;
  localparam logic [3:0] ALU_LSR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  typedef enum logic [3:0] {
    OP_ILLEGAL,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_ORR,
    OP_LSL,
    OP_LSR,
    OP_LDUR,
    OP_STUR,
    OP_ADDI,
    OP_SUBI,
    OP_CBZ,
    OP_CBNZ,
    OP_B,
    OP_HALT
  } op_e;

endpackage

// File: rtl/legv8_regfile.sv
// 31 x XLEN register file with XZR at index 31, two combinational read
// ports with same-cycle write bypass, one write port, async clear.
import legv8_pkg::*;

module legv8_regfile (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [0:NREGS-2];
  logic            wr_en;

  assign wr_en = we && (wa != 5'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // XZR check comes first so index 31 never touches the array.
  always_comb begin
    rd1 = '0;
    if (ra1 == 5'd31)                 rd1 = '0;
    else if (wr_en && (wa == ra1))    rd1 = wd;
    else                              rd1 = regs[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 == 5'd31)                 rd2 = '0;
    else if (wr_en && (wa == ra2))    rd2 = wd;
    else                              rd2 = regs[ra2];
  end

endmodule

// File: rtl/instruction_decode.sv
// LEGv8 decode stage: control decode, immediate generation, register file
// and early branch resolution feeding PCSrc/BranchAddress back to fetch.
import legv8_pkg::*;

module instruction_decode (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] PC,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic            PCSrc,
  output logic [XLEN-1:0] BranchAddress,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic [XLEN-1:0] imm_ext,
  output logic [4:0]      dest_reg,
  output logic [3:0]      alu_ctrl,
  output logic            ALUSrc,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            halt,
  output logic            illegal
);

  op_e             op;
  logic            reg2loc;
  logic            is_branch;
  logic            rf_we;
  logic [4:0]      ra2;
  logic [XLEN-1:0] imm_raw;

  // Longest opcode field first so that short prefixes never shadow a longer match.
  always_comb begin
    op = OP_ILLEGAL;
    case (instruction[31:21])
      OPC_ADD:  op = OP_ADD;
      OPC_SUB:  op = OP_SUB;
      OPC_AND:  op = OP_AND;
      OPC_ORR:  op = OP_ORR;
      OPC_LSL:  op = OP_LSL;
      OPC_LSR:  op = OP_LSR;
      OPC_LDUR: op = OP_LDUR;
      OPC_STUR: op = OP_STUR;
      OPC_HALT: op = OP_HALT;
      default: begin
        case (instruction[31:22])
          OPC_ADDI: op = OP_ADDI;
          OPC_SUBI: op = OP_SUBI;
          default: begin
            case (instruction[31:24])
              OPC_CBZ:  op = OP_CBZ;
              OPC_CBNZ: op = OP_CBNZ;
              default: begin
                if (instruction[31:26] == OPC_B) op = OP_B;
              end
            endcase
          end
        endcase
      end
    endcase
  end

  assign reg2loc = (op == OP_STUR) || (op == OP_CBZ) || (op == OP_CBNZ);
  assign ra2     = reg2loc ? instruction[4:0] : instruction[20:16];
  assign rf_we   = wb_reg_write && !rst && (op != OP_HALT) && (op != OP_ILLEGAL);

  legv8_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (instruction[9:5]),
    .ra2 (ra2),
    .we  (rf_we),
    .wa  (wb_reg),
    .wd  (wb_data),
    .rd1 (read_data1),
    .rd2 (read_data2)
  );

  assign dest_reg = instruction[4:0];

  always_comb begin
    imm_raw = '0;
    case (op)
      OP_ADDI, OP_SUBI:   imm_raw = {52'b0, instruction[21:10]};
      OP_LDUR, OP_STUR:   imm_raw = {{55{instruction[20]}}, instruction[20:12]};
      OP_LSL, OP_LSR:     imm_raw = {58'b0, instruction[15:10]};
      OP_CBZ, OP_CBNZ:    imm_raw = {{45{instruction[23]}}, instruction[23:5]};
      OP_B:               imm_raw = {{38{instruction[25]}}, instruction[25:0]};
      default:            imm_raw = '0;
    endcase
  end

  assign is_branch = (op == OP_B) || (op == OP_CBZ) || (op == OP_CBNZ);

  always_comb begin
    alu_ctrl      = ALU_AND;
    ALUSrc        = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    PCSrc         = 1'b0;
    halt          = 1'b0;
    illegal       = 1'b0;
    imm_ext       = imm_raw;
    BranchAddress = is_branch ? PC + (imm_raw << 2) : PC + 64'd4;
    case (op)
      OP_ADD:  begin RegWrite = 1'b1; alu_ctrl = ALU_ADD; end
      OP_SUB:  begin RegWrite = 1'b1; alu_ctrl = ALU_SUB; end
      OP_AND:  begin RegWrite = 1'b1; alu_ctrl = ALU_AND; end
      OP_ORR:  begin RegWrite = 1'b1; alu_ctrl = ALU_ORR; end
      OP_LSL:  begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_ctrl = ALU_LSL; end
      OP_LSR:  begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_ctrl = ALU_LSR; end
      OP_ADDI: begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_ctrl = ALU_ADD; end
      OP_SUBI: begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_ctrl = ALU_SUB; end
      OP_LDUR: begin
        ALUSrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
        alu_ctrl = ALU_ADD;
      end
      OP_STUR: begin ALUSrc = 1'b1; MemWrite = 1'b1; alu_ctrl = ALU_ADD; end
      OP_CBZ:  begin alu_ctrl = ALU_PASS; PCSrc = (read_data2 == '0); end
      OP_CBNZ: begin alu_ctrl = ALU_PASS; PCSrc = (read_data2 != '0); end
      OP_B:    PCSrc = 1'b1;
      OP_HALT: halt = 1'b1;
      default: illegal = 1'b1;
    endcase
    // Reset silences everything fetch and execute could act on.
    if (rst) begin
      alu_ctrl      = ALU_AND;
      ALUSrc        = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      PCSrc         = 1'b0;
      halt          = 1'b0;
      illegal       = 1'b0;
      imm_ext       = '0;
      BranchAddress = '0;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: register file, branches, control
// decode, halt/illegal, bypass and asynchronous reset.
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [63:0] PC;
  logic        wb_reg_write;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        PCSrc;
  logic [63:0] BranchAddress;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] imm_ext;
  logic [4:0]  dest_reg;
  logic [3:0]  alu_ctrl;
  logic        ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
  logic        halt, illegal;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  instruction_decode dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .PC            (PC),
    .wb_reg_write  (wb_reg_write),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .PCSrc         (PCSrc),
    .BranchAddress (BranchAddress),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .imm_ext       (imm_ext),
    .dest_reg      (dest_reg),
    .alu_ctrl      (alu_ctrl),
    .ALUSrc        (ALUSrc),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .RegWrite      (RegWrite),
    .halt          (halt),
    .illegal       (illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic write_reg(input logic [4:0] r, input logic [63:0] v);
    @(negedge clk);
    wb_reg_write = 1'b1;
    wb_reg       = r;
    wb_data      = v;
    @(posedge clk);
    #1;
    wb_reg_write = 1'b0;
  endtask

  // Reads Rn through an ADD so the decode is legal.
  task automatic read_reg(input logic [4:0] r, output logic [63:0] v);
    instruction = {11'h458, 5'd0, 6'd0, r, 5'd0};
    #1;
    v = read_data1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    PC = 64'h100;
    instruction = {6'h05, 26'd3};
    wb_reg_write = 1'b0; wb_reg = '0; wb_data = '0;
    #2;
    checks++;
    if (PCSrc !== 1'b0) begin failures++; $display("FAIL reset_pcsrc got=%0b exp=0", PCSrc); end
    checks++;
    if (BranchAddress !== 64'h0) begin failures++; $display("FAIL reset_baddr got=%h exp=0", BranchAddress); end
    checks++;
    if ({RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, halt, illegal, alu_ctrl} !== 11'b0 || imm_ext !== 64'h0) begin
      failures++; $display("FAIL reset_ctrl got_imm=%h ctrl=%b exp=0", imm_ext,
        {RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, halt, illegal, alu_ctrl});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_regfile;
    logic [63:0] v;
    read_reg(5'd1, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL rf_x1_reset got=%h exp=0", v); end
    read_reg(5'd2, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL rf_x2_reset got=%h exp=0", v); end
    write_reg(5'd1, 64'd5);
    read_reg(5'd1, v);
    checks++; if (v !== 64'd5) begin failures++; $display("FAIL rf_x1_write got=%h exp=5", v); end
    write_reg(5'd31, 64'd7);
    read_reg(5'd31, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL rf_xzr got=%h exp=0", v); end
  endtask

  task automatic test_branch_b;
    PC = 64'h100;
    instruction = {6'h05, 26'd3};
    #1;
    checks++; if (PCSrc !== 1'b1) begin failures++; $display("FAIL b_pcsrc got=%0b exp=1", PCSrc); end
    checks++; if (BranchAddress !== 64'h10C) begin failures++; $display("FAIL b_fwd got=%h exp=10c", BranchAddress); end
    instruction = {6'h05, 26'h3FFFFFF};
    #1;
    checks++; if (BranchAddress !== 64'hFC) begin failures++; $display("FAIL b_back got=%h exp=fc", BranchAddress); end
    checks++; if (imm_ext !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL b_imm got=%h exp=all ones", imm_ext); end
  endtask

  task automatic test_cbz_cbnz;
    PC = 64'h20;
    instruction = {8'hB4, 19'd4, 5'd3};
    #1;
    checks++; if (PCSrc !== 1'b1) begin failures++; $display("FAIL cbz_taken got=%0b exp=1", PCSrc); end
    checks++; if (BranchAddress !== 64'h30) begin failures++; $display("FAIL cbz_target got=%h exp=30", BranchAddress); end
    checks++; if (alu_ctrl !== 4'b0111) begin failures++; $display("FAIL cbz_alu got=%b exp=0111", alu_ctrl); end
    write_reg(5'd3, 64'd9);
    #1;
    checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL cbz_not_taken got=%0b exp=0", PCSrc); end
    instruction = {8'hB5, 19'd4, 5'd3};
    #1;
    checks++; if (PCSrc !== 1'b1) begin failures++; $display("FAIL cbnz_taken got=%0b exp=1", PCSrc); end
    instruction = {8'hB5, 19'd4, 5'd2};
    #1;
    checks++; if (PCSrc !== 1'b0) begin failures++; $display("FAIL cbnz_not_taken got=%0b exp=0", PCSrc); end
  endtask

  task automatic test_controls;
    write_reg(5'd2, 64'h1234);
    PC = 64'h40;
    // ADD X1, X2, X3
    instruction = {11'h458, 5'd3, 6'd0, 5'd2, 5'd1};
    #1;
    checks++;
    if ({RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl} !== 9'b1_0_0_0_0_0010) begin
      failures++; $display("FAIL add_ctrl got=%b exp=100000010", {RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl});
    end
    checks++;
    if (read_data1 !== 64'h1234 || read_data2 !== 64'd9 || dest_reg !== 5'd1) begin
      failures++; $display("FAIL add_operands got=%h/%h/%0d exp=1234/9/1", read_data1, read_data2, dest_reg);
    end
    checks++; if (BranchAddress !== 64'h44) begin failures++; $display("FAIL add_pc4 got=%h exp=44", BranchAddress); end
    // LDUR X5, [X2, #-8]
    instruction = {11'h7C2, 9'h1F8, 2'b00, 5'd2, 5'd5};
    #1;
    checks++;
    if ({RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl} !== 9'b1_1_1_0_1_0010) begin
      failures++; $display("FAIL ldur_ctrl got=%b exp=111010010", {RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl});
    end
    checks++; if (imm_ext !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL ldur_imm got=%h exp=fffffffffffffff8", imm_ext); end
    // STUR X1, [X2, #16]
    instruction = {11'h7C0, 9'd16, 2'b00, 5'd2, 5'd1};
    #1;
    checks++;
    if ({RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl} !== 9'b0_1_0_1_0_0010) begin
      failures++; $display("FAIL stur_ctrl got=%b exp=010100010", {RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl});
    end
    checks++; if (read_data2 !== 64'd5) begin failures++; $display("FAIL stur_rt got=%h exp=5", read_data2); end
    checks++; if (imm_ext !== 64'd16) begin failures++; $display("FAIL stur_imm got=%h exp=10", imm_ext); end
    // ADDI X6, X2, #0xABC
    instruction = {10'h244, 12'hABC, 5'd2, 5'd6};
    #1;
    checks++;
    if (imm_ext !== 64'hABC || ALUSrc !== 1'b1 || RegWrite !== 1'b1 || alu_ctrl !== 4'b0010) begin
      failures++; $display("FAIL addi got_imm=%h alusrc=%0b rw=%0b alu=%b exp=abc/1/1/0010", imm_ext, ALUSrc, RegWrite, alu_ctrl);
    end
    // SUBI with top immediate bit set stays zero-extended
    instruction = {10'h344, 12'hFFF, 5'd2, 5'd6};
    #1;
    checks++;
    if (imm_ext !== 64'hFFF || alu_ctrl !== 4'b0110) begin
      failures++; $display("FAIL subi got_imm=%h alu=%b exp=fff/0110", imm_ext, alu_ctrl);
    end
    // LSL X7, X2, #5
    instruction = {11'h69B, 5'd0, 6'd5, 5'd2, 5'd7};
    #1;
    checks++;
    if (imm_ext !== 64'd5 || alu_ctrl !== 4'b0011 || ALUSrc !== 1'b1 || RegWrite !== 1'b1) begin
      failures++; $display("FAIL lsl got_imm=%h alu=%b exp=5/0011", imm_ext, alu_ctrl);
    end
    // ORR and SUB encodings
    instruction = {11'h550, 5'd3, 6'd0, 5'd2, 5'd1};
    #1;
    checks++; if (alu_ctrl !== 4'b0001) begin failures++; $display("FAIL orr_alu got=%b exp=0001", alu_ctrl); end
    instruction = {11'h658, 5'd3, 6'd0, 5'd2, 5'd1};
    #1;
    checks++; if (alu_ctrl !== 4'b0110) begin failures++; $display("FAIL sub_alu got=%b exp=0110", alu_ctrl); end
  endtask

  task automatic test_halt_illegal;
    logic [63:0] v;
    PC = 64'h80;
    instruction = 32'hFFE00000;
    #1;
    checks++; if (halt !== 1'b1 || illegal !== 1'b0) begin failures++; $display("FAIL halt_flag got=%0b/%0b exp=1/0", halt, illegal); end
    checks++;
    if ({PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl} !== 10'b0) begin
      failures++; $display("FAIL halt_ctrl got=%b exp=0", {PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, alu_ctrl});
    end
    instruction = 32'h0000_0000;
    #1;
    checks++; if (illegal !== 1'b1 || halt !== 1'b0) begin failures++; $display("FAIL illegal_flag got=%0b/%0b exp=1/0", illegal, halt); end
    checks++;
    if ({PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg} !== 6'b0) begin
      failures++; $display("FAIL illegal_ctrl got=%b exp=0", {PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg});
    end
    write_reg(5'd8, 64'h55);
    read_reg(5'd8, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL illegal_nowrite got=%h exp=0", v); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    instruction = {11'h458, 5'd4, 6'd0, 5'd4, 5'd9};
    wb_reg_write = 1'b1; wb_reg = 5'd4; wb_data = 64'hAA;
    #1;
    checks++;
    if (read_data1 !== 64'hAA || read_data2 !== 64'hAA) begin
      failures++; $display("FAIL bypass got=%h/%h exp=aa/aa", read_data1, read_data2);
    end
    @(posedge clk);
    #1;
    wb_reg_write = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] v;
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      exp_q.push_back(v);
      write_reg(5'(10 + i), v);
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(5'(10 + i), v);
      e = exp_q.pop_front();
      checks++; if (v !== e) begin failures++; $display("FAIL b2b_x%0d got=%h exp=%h", 10 + i, v, e); end
    end
  endtask

  task automatic test_reset_midrun;
    logic [63:0] v;
    @(negedge clk);
    PC = 64'h100;
    instruction = {6'h05, 26'd3};
    #2;
    rst = 1'b1;
    #1;
    checks++; if (PCSrc !== 1'b0 || BranchAddress !== 64'h0) begin
      failures++; $display("FAIL midrst_branch got=%0b/%h exp=0/0", PCSrc, BranchAddress);
    end
    read_reg(5'd1, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL midrst_x1 got=%h exp=0", v); end
    read_reg(5'd3, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL midrst_x3 got=%h exp=0", v); end
    @(negedge clk);
    rst = 1'b0;
    read_reg(5'd2, v);
    checks++; if (v !== 64'h0) begin failures++; $display("FAIL postrst_x2 got=%h exp=0", v); end
  endtask

  initial begin
    test_reset;
    test_regfile;
    test_branch_b;
    test_cbz_cbnz;
    test_controls;
    test_halt_illegal;
    test_bypass;
    test_back_to_back;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
